serdes_seq_ctrl: RTL and testbench
==================================

Name: serdes_seq_ctrl

Overview:
Sequencer for the 8-bit SERDES core: it shares the single shift datapath between a transmit requester and a receive requester. For each granted frame it drives the core's load, shift-out and shift-in enables for exactly WIDTH cycles. It returns the deserialized byte with a one-cycle valid strobe. It sits between the user-facing byte interfaces and the SERDES core enables (data_en / ser_en / par_en).

Parameters:
WIDTH, 8, bits per frame; shift counter runs 0..WIDTH-1
GAP_CYCLES, 1, idle cycles inserted after every frame before the next grant (0 allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_valid  input  1  TX requester has a byte
tx_data  input  WIDTH  byte to serialize, sampled on tx_valid&tx_ready
tx_ready  output  1  controller accepts tx_data this cycle
tx_done  output  1  one-cycle pulse: last TX bit shifted
rx_req  input  1  RX requester wants one frame received (level)
rx_gnt  output  1  one-cycle pulse: RX frame granted/started
rx_valid  output  1  one-cycle pulse: rx_data holds received byte
rx_data  output  WIDTH  registered received byte, held until next capture
sd_load  output  1  to core data_en: load sd_par_out into shift register
sd_par_out  output  WIDTH  to core data_8b_in
sd_ser_en  output  1  to core ser_en: shift one bit out
sd_par_en  output  1  to core par_en: shift one bit in
sd_par_in  input  WIDTH  from core data_out (deserialized byte)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, rx_data=0, sd_par_out=0, bit counter 0, gap counter 0, last_grant=RX (so TX wins the first tie).
- States: IDLE, LOAD, SHIFT_TX, SHIFT_RX, CAPTURE, GAP.
- IDLE arbitration (combinational from registered state): only tx_valid -> tx_ready=1; only rx_req -> rx_gnt=1; both -> grant the side not equal to last_grant (round-robin); neither -> stay. Grant updates last_grant. tx_ready/rx_gnt are never high outside IDLE, never both high.
- TX frame, accept in cycle T: tx_data latched into sd_par_out; T+1 LOAD: sd_load=1; T+2..T+1+WIDTH SHIFT_TX: sd_ser_en=1 each cycle, counter increments; tx_done=1 in cycle T+1+WIDTH (last shift); then GAP.
- RX frame, grant in cycle T: T+1..T+WIDTH SHIFT_RX: sd_par_en=1 each cycle; T+WIDTH+1 CAPTURE: rx_data<=sd_par_in, rx_valid=1 in the following cycle (registered), enter GAP. rx_valid is a registered pulse; no backpressure.
- GAP: counts GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0: CAPTURE/last SHIFT_TX goes directly to IDLE.
- Exactly one of sd_load/sd_ser_en/sd_par_en high in any cycle, or none.
- tx_valid dropping or tx_data changing after acceptance has no effect; rx_req dropping after grant does not abort the frame.
- sd_par_out holds the last accepted TX byte until the next acceptance.
- Reset asserted mid-frame: immediate return to reset values; no tx_done/rx_valid emitted for the aborted frame.
- Back-to-back TX throughput with GAP_CYCLES=1: one byte every WIDTH+3 cycles.

Test Plan:
- Single TX 0xA5, GAP=1: tx_ready at T, sd_load at T+1 with sd_par_out=0xA5, sd_ser_en T+2..T+9 (8 cycles), tx_done at T+9, tx_ready next possible at T+11.
- Single RX: rx_req=1 with core driving sd_par_in=0x3C -> rx_gnt pulse, sd_par_en 8 cycles, rx_data=0x3C with rx_valid one-cycle pulse; busy low afterwards.
- Simultaneous tx_valid and rx_req held high for 4 frames after reset -> grants alternate TX,RX,TX,RX; never both in the same cycle.
- Enable exclusivity: random tx/rx traffic for 1000 cycles -> assertion that at most one of sd_load/sd_ser_en/sd_par_en is high and the count of sd_ser_en per TX frame is exactly 8.
- Reset at 4th shift of TX frame 0xFF -> all outputs 0 same cycle, no tx_done; after release a new TX 0x01 completes normally.
- GAP_CYCLES=0 build: back-to-back TX bytes 0x11,0x22 -> second tx_ready in the cycle after first tx_done; period 10 cycles.

Source files
------------

// File: rtl/serdes_seq_ctrl.sv
// Sequencer sharing one SERDES shift datapath between a TX byte
// requester and an RX frame requester, with round-robin arbitration.
module serdes_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_done,
  input  logic             rx_req,
  output logic             rx_gnt,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             sd_load,
  output logic [WIDTH-1:0] sd_par_out,
  output logic             sd_ser_en,
  output logic             sd_par_en,
  input  logic [WIDTH-1:0] sd_par_in,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_TX = 3'd2;
  localparam logic [2:0] SHIFT_RX = 3'd3;
  localparam logic [2:0] CAPTURE  = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;

  // With no gap configured a finished frame returns straight to IDLE
  localparam logic [2:0] POST = (GAP_CYCLES > 0) ? GAP : IDLE;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;
  logic             last_rx;
  logic             rx_valid_q;
  logic [WIDTH-1:0] rx_data_q;
  logic [WIDTH-1:0] par_out_q;
  logic             grant_tx;
  logic             grant_rx;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  // Round-robin: on a tie the side that did not win last time goes
  always_comb begin
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    if (state == IDLE) begin
      grant_tx = tx_valid & (~rx_req | last_rx);
      grant_rx = rx_req & (~tx_valid | ~last_rx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gap_cnt    <= '0;
      last_rx    <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      par_out_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_tx) begin
            par_out_q <= tx_data;
            last_rx   <= 1'b0;
            state     <= LOAD;
          end else if (grant_rx) begin
            last_rx <= 1'b1;
            cnt     <= '0;
            state   <= SHIFT_RX;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT_TX;
        end
        SHIFT_TX: begin
          if (cnt_last) begin
            cnt     <= '0;
            gap_cnt <= '0;
            state   <= POST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_RX: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          rx_data_q  <= sd_par_in;
          rx_valid_q <= 1'b1;
          gap_cnt    <= '0;
          state      <= POST;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_ready   = grant_tx;
  assign rx_gnt     = grant_rx;
  assign tx_done    = (state == SHIFT_TX) & cnt_last;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign sd_load    = (state == LOAD);
  assign sd_ser_en  = (state == SHIFT_TX);
  assign sd_par_en  = (state == SHIFT_RX);
  assign sd_par_out = par_out_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serdes_seq_ctrl.sv
// Directed bench for serdes_seq_ctrl: GAP_CYCLES=1 and
// GAP_CYCLES=0 instances share one clock and reset.
module tb_serdes_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid, tx_ready, tx_done;
  logic [7:0] tx_data;
  logic       rx_req, rx_gnt, rx_valid;
  logic [7:0] rx_data, sd_par_out, sd_par_in;
  logic       sd_load, sd_ser_en, sd_par_en, busy;

  logic       d0_tx_valid, d0_tx_ready, d0_tx_done;
  logic [7:0] d0_tx_data;
  logic       d0_rx_gnt, d0_rx_valid;
  logic [7:0] d0_rx_data, d0_sd_par_out;
  logic       d0_sd_load, d0_sd_ser_en, d0_sd_par_en, d0_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serdes_seq_ctrl #(.WIDTH(8), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done),
    .rx_req(rx_req), .rx_gnt(rx_gnt),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .sd_load(sd_load), .sd_par_out(sd_par_out),
    .sd_ser_en(sd_ser_en), .sd_par_en(sd_par_en),
    .sd_par_in(sd_par_in), .busy(busy)
  );

  serdes_seq_ctrl #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(d0_tx_valid), .tx_data(d0_tx_data),
    .tx_ready(d0_tx_ready), .tx_done(d0_tx_done),
    .rx_req(1'b0), .rx_gnt(d0_rx_gnt),
    .rx_valid(d0_rx_valid), .rx_data(d0_rx_data),
    .sd_load(d0_sd_load), .sd_par_out(d0_sd_par_out),
    .sd_ser_en(d0_sd_ser_en), .sd_par_en(d0_sd_par_en),
    .sd_par_in(8'h00), .busy(d0_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {8'h00, tx_ready, tx_done, rx_gnt, rx_valid,
            sd_load, sd_ser_en, sd_par_en, busy,
            rx_data, sd_par_out};
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tx_valid = 0; tx_data = 0; rx_req = 0; sd_par_in = 0;
    d0_tx_valid = 0; d0_tx_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, ng, cnt, ndone, na, a0, a1, dn;
    logic [3:0] seq;
    logic saw;

    // Reset values
    rst_n = 1'b0;
    tx_valid = 0; tx_data = 0; rx_req = 0; sd_par_in = 0;
    d0_tx_valid = 0; d0_tx_data = 0;
    #2;
    chk("reset_outs", outs(), 32'd0);
    do_reset();
    #1;
    chk("post_reset_idle", outs(), 32'd0);

    // Single TX 0xA5
    tx_valid = 1; tx_data = 8'hA5;
    #1;
    chk("tx_ready_T", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 0; tx_data = 8'h5A;
    #1;
    chk("load_T1", {31'd0, sd_load}, 32'd1);
    chk("par_out_T1", {24'd0, sd_par_out}, 32'hA5);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ser_en", {31'd0, sd_ser_en}, 32'd1);
      chk("tx_done_pos", {31'd0, tx_done}, (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    tx_valid = 1; tx_data = 8'h11;
    #1;
    chk("gap_no_ready", {30'd0, tx_ready, sd_ser_en}, 32'd0);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("tx_ready_T11", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 0;
    wait_idle("idle_after_tx");

    // Single RX 0x3C
    sd_par_in = 8'h3C; rx_req = 1;
    #1;
    chk("rx_gnt", {30'd0, rx_gnt, tx_ready}, 32'd2);
    tick();
    rx_req = 0;
    for (int i = 0; i < 8; i++) begin
      chk("par_en", {30'd0, sd_par_en, sd_ser_en}, 32'd2);
      tick();
    end
    chk("capture", {29'd0, sd_par_en, rx_valid, busy}, 32'd1);
    tick();
    chk("rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx_data", {24'd0, rx_data}, 32'h3C);
    tick();
    chk("rx_valid_pulse", {30'd0, rx_valid, busy}, 32'd0);
    chk("rx_data_hold", {24'd0, rx_data}, 32'h3C);

    // Round-robin with both requesters held
    do_reset();
    tx_valid = 1; tx_data = 8'h77; rx_req = 1;
    ng = 0; n = 0; seq = 4'b0;
    while (ng < 4 && n < 120) begin
      #1;
      chk("no_dual_grant", {30'd0, tx_ready, rx_gnt} & 32'h3 & {32{tx_ready & rx_gnt}}, 32'd0);
      if (tx_ready) begin seq[ng] = 1'b0; ng++; end
      else if (rx_gnt) begin seq[ng] = 1'b1; ng++; end
      tick();
      n++;
    end
    chk("rr_count", ng, 4);
    chk("rr_order", {28'd0, seq}, 32'b1010);
    tx_valid = 0; rx_req = 0;
    wait_idle("idle_after_rr");

    // Random traffic: enable exclusivity and shifts per TX frame
    cnt = 0; ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      rx_req = 1'($urandom_range(0, 1));
      sd_par_in = 8'($urandom);
      #1;
      chk("en_onehot0",
          {31'd0, (32'(sd_load) + 32'(sd_ser_en) + 32'(sd_par_en)) > 1}, 32'd0);
      if (sd_load) cnt = 0;
      if (sd_ser_en) cnt++;
      if (tx_done) begin
        ndone++;
        chk("ser_per_frame", cnt, 8);
      end
      tick();
    end
    chk("rand_saw_done", {31'd0, ndone > 0}, 32'd1);
    tx_valid = 0; rx_req = 0;
    wait_idle("idle_after_rand");

    // Reset at 4th shift of TX 0xFF
    tx_valid = 1; tx_data = 8'hFF;
    #1;
    chk("ff_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 0;
    chk("ff_load", {31'd0, sd_load}, 32'd1);
    repeat (4) tick();
    chk("ff_shift4", {31'd0, sd_ser_en}, 32'd1);
    rst_n = 0;
    #1;
    chk("abort_outs", outs(), 32'd0);
    tick();
    chk("abort_hold", outs(), 32'd0);
    rst_n = 1;
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_done || busy) saw = 1;
    end
    chk("no_done_after_abort", {31'd0, saw}, 32'd0);
    tx_valid = 1; tx_data = 8'h01;
    #1;
    chk("t01_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 0;
    chk("t01_load", {23'd0, sd_load, sd_par_out}, 32'h101);
    n = 0;
    while (!tx_done && n < 20) begin
      tick();
      n++;
    end
    chk("t01_done_latency", n, 8);
    wait_idle("idle_after_t01");

    // GAP_CYCLES=0 back-to-back TX
    d0_tx_valid = 1; d0_tx_data = 8'h11;
    na = 0; a0 = -1; a1 = -1; dn = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (d0_tx_done && dn < 0) dn = i;
      if (d0_tx_ready) begin
        if (na == 0) a0 = i; else a1 = i;
        na++;
      end
      tick();
      if (na == 1) d0_tx_data = 8'h22;
      if (na == 2) break;
    end
    d0_tx_valid = 0;
    chk("g0_accepts", na, 2);
    chk("g0_period", a1 - a0, 10);
    chk("g0_after_done", a1, dn + 1);
    chk("g0_second_load", {23'd0, d0_sd_load, d0_sd_par_out}, 32'h122);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
